// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the radix-2 shift-add sequential multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign.
module seq_mul_signfix #(
  parameter int W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_mul_core.sv
// Parametrised shift-add multiplier: magnitudes are multiplied unsigned over
// WIDTH cycles, then the sign is applied once in the FIX state.
module seq_mul_core
  import seq_mul_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH + 1);

  state_t            state_reg;
  logic [WIDTH-1:0]  mcand_reg;
  logic [PW-1:0]     acc_reg;
  logic [CW-1:0]     count_reg;
  logic              neg_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [PW-1:0]     product_reg;

  logic              sgn;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     result;

  assign sgn = signed_mode & SIGNED_EN;

  seq_mul_signfix #(.W(WIDTH)) u_fix_a (
    .neg  (sgn & a[WIDTH-1]),
    .din  (a),
    .dout (a_mag)
  );

  seq_mul_signfix #(.W(WIDTH)) u_fix_b (
    .neg  (sgn & b[WIDTH-1]),
    .din  (b),
    .dout (b_mag)
  );

  seq_mul_signfix #(.W(PW)) u_fix_p (
    .neg  (neg_reg),
    .din  (acc_reg),
    .dout (result)
  );

  // Upper half plus conditional multiplicand; the extra bit keeps the carry
  // so that all-ones unsigned operands still produce the full product.
  assign sum      = {1'b0, acc_reg[PW-1:WIDTH]}
                  + {1'b0, (acc_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  assign acc_next = {sum, acc_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg <= a_mag;
            acc_reg   <= {{WIDTH{1'b0}}, b_mag};
            neg_reg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            count_reg <= CW'(WIDTH);
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) state_reg <= FIX;
        end
        FIX: begin
          product_reg <= result;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_seq_mul_core.sv
// Scoreboard bench: one 4-bit signed-capable core and two 8-bit cores
// (signed-capable and unsigned-only) share stimulus; each has its own queue.
module tb_seq_mul_core;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       busy4, done4, busy8s, done8s, busy8u, done8u;
  logic [7:0]  prod4;
  logic [15:0] prod8s, prod8u;

  seq_mul_core #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mul_core #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8s (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a_in), .b(b_in), .busy(busy8s), .done(done8s), .product(prod8s)
  );

  seq_mul_core #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut8u (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a_in), .b(b_in), .busy(busy8u), .done(done8u), .product(prod8u)
  );

  typedef struct {
    int     n;
    longint prod;
  } exp_t;

  exp_t   q[3][$];
  longint lastp[3];
  int     last_done[3];
  int     cyc;
  int     n_cmp;
  int     n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic bit sen(int k);
    return (k != 2);
  endfunction

  // Reference: interpret operands as integers and multiply, modulo 2^(2W).
  function automatic longint model(int w, bit se, bit sm, longint av, longint bv);
    longint sa, sb, half, full;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa = av & (full - 1);
    sb = bv & (full - 1);
    if (se && sm) begin
      if (sa >= half) sa = sa - full;
      if (sb >= half) sb = sb - full;
    end
    return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check(string nm, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Monitor: expected busy/done windows derive from the accepted start edge.
  always @(negedge clk) begin
    logic [15:0] pw;
    logic        bw, dw;
    for (int k = 0; k < 3; k++) begin
      bit eb, ed;
      eb = 1'b0;
      ed = 1'b0;
      case (k)
        0:       begin pw = {8'h00, prod4}; bw = busy4;  dw = done4;  end
        1:       begin pw = prod8s;         bw = busy8s; dw = done8s; end
        default: begin pw = prod8u;         bw = busy8u; dw = done8u; end
      endcase
      if (q[k].size() > 0 && q[k][0].n <= cyc) begin
        if (cyc <= q[k][0].n + wid(k)) eb = 1'b1;
        else if (cyc == q[k][0].n + wid(k) + 1) ed = 1'b1;
      end
      check("busy", k, longint'(bw), longint'(eb));
      check("done", k, longint'(dw), longint'(ed));
      if (ed) begin
        lastp[k] = q[k][0].prod;
        void'(q[k].pop_front());
        $display("dut%0d result at cyc=%0d product=%0h expected=%0h", k, cyc, pw, lastp[k]);
      end
      check("product", k, longint'(pw), lastp[k]);
    end
  end

  task automatic cycle(bit st, logic [7:0] av, logic [7:0] bv, bit sm);
    int m;
    @(posedge clk);
    #1;
    start       = st;
    a_in        = av;
    b_in        = bv;
    signed_mode = sm;
    if (st) begin
      m = cyc + 1;
      for (int k = 0; k < 3; k++) begin
        if (m > last_done[k]) begin
          q[k].push_back('{n: m, prod: model(wid(k), sen(k), sm, longint'(av), longint'(bv))});
          last_done[k] = m + wid(k) + 1;
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic op(logic [7:0] av, logic [7:0] bv, bit sm);
    cycle(1'b1, av, bv, sm);
    idle(11);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      lastp[k]     = 0;
      last_done[k] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    a_in = 8'h00;
    b_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      lastp[k]     = 0;
      last_done[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    op(8'h03, 8'h05, 1'b0);
    op(8'h07, 8'h04, 1'b0);
    op(8'hFF, 8'hFF, 1'b0);
    op(8'hF8, 8'hF8, 1'b1);
    op(8'hF8, 8'h07, 1'b1);
    op(8'h80, 8'h80, 1'b1);
    op(8'h00, 8'hFF, 1'b1);
    op(8'hFF, 8'h02, 1'b1);

    // Second start during RUN must be ignored.
    cycle(1'b1, 8'h03, 8'h05, 1'b0);
    cycle(1'b0, 8'h01, 8'h01, 1'b0);
    cycle(1'b1, 8'h01, 8'h01, 1'b0);
    idle(11);
    op(8'h01, 8'h01, 1'b0);

    // Start held continuously with fixed operands.
    repeat (40) cycle(1'b1, 8'hA5, 8'h3C, 1'b1);
    idle(11);

    // Reset in the middle of RUN aborts the operation.
    cycle(1'b1, 8'h03, 8'h05, 1'b0);
    idle(2);
    do_reset();
    op(8'h03, 8'h05, 1'b0);

    // Random traffic with operands changing every cycle.
    repeat (400) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle(($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    waited = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && waited < 50) begin
      idle(1);
      waited++;
    end
    n_cmp++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding expected 0",
               q[0].size() + q[1].size() + q[2].size());
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul_core.md
Name: seq_mul_core

Overview:
Parametrised radix-2 shift-add sequential multiplier. It generalises the team's 4-bit start-pulse multiplier to any operand width and adds a per-operation signed/unsigned mode. It also adds a busy/done handshake and holds the product until the next operation is accepted. It sits behind the tt_um pin wrapper, which drives operands from ui_in and start/mode from uio_in. For WIDTH=4 the wrapper reproduces the existing pinout.

Parameters:
WIDTH, 8, operand width in bits (legal 2..16); product is 2*WIDTH bits
SIGNED_EN, 1, 1 = honour signed_mode; 0 = signed_mode ignored, always unsigned

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
signed_mode  in  1  1 = operands two's complement; captured with start
a  in  WIDTH  multiplicand; captured with start
b  in  WIDTH  multiplier; captured with start
busy  out  1  high in RUN and FIX states
done  out  1  one-cycle pulse when product becomes valid
product  out  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, busy=0, done=0, product=0, internal acc/count=0.
- States:
  - IDLE: busy=0. On start=1, capture operands.
    - Mode sgn = signed_mode & SIGNED_EN.
    - Magnitudes: |a| and |b| when sgn, else raw values.
    - neg flag = sgn & (a[MSB] ^ b[MSB]).
    - count = WIDTH.
    - Go to RUN.
  - RUN: each cycle, if multiplier LSB=1, add multiplicand into the upper half of acc. Use a WIDTH+1-bit adder so the carry is kept.
    - Then shift {carry, acc, multiplier} right by 1 and decrement count.
    - When count reaches 1, go to FIX.
  - FIX: product <= neg ? -acc : acc (2*WIDTH-bit two's complement). Pulse done=1. Go to IDLE.
- Latency: start sampled high at edge N gives done=1 and a valid product in the cycle after edge N+WIDTH+1. Total is WIDTH+1 busy cycles.
- Throughput: start held permanently high gives one operation every WIDTH+2 cycles, because IDLE lasts one cycle between operations.
- start is ignored in RUN and FIX. No queueing, and it is not remembered.
- product and done change only on the FIX edge. product is untouched in IDLE and RUN, so the previous result stays readable while busy.
- Arithmetic edge cases:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits in the WIDTH-bit unsigned magnitude register, so no overflow.
  - Signed (-2^(W-1))^2 = 2^(2W-2) fits in the 2W-bit signed product.
  - A zero operand with neg=1 yields 0, not -0, because negating 0 gives 0.
- Changing a, b or signed_mode while busy has no effect on the operation in progress.
- rst_n asserted mid-operation aborts immediately: product=0, done=0, IDLE. No partial result is ever presented.
- Unsigned mode with all-ones operands: (2^W-1)^2 fits in 2W bits; the carry bit must not be dropped.

Decomposition:
- Package seq_mul_pkg:
  - state enum {IDLE, RUN, FIX}
  - function clog2 for the count width (count width = clog2(WIDTH+1))
  - localparam PW = 2*WIDTH is derived inside the module.
- One sub-module, seq_mul_signfix: combinational conditional two's-complement negate, parametrised by width. It is instantiated twice at WIDTH for operand magnitudes and once at 2*WIDTH for the result.
- The tt_um wrapper is separate and not part of this block.

Test Plan:
- WIDTH=4, unsigned, a=3, b=5, start pulsed one cycle -> busy for 5 cycles, done pulse exactly 5 cycles after the start edge, product=15; then a=7, b=4 -> product=28.
- WIDTH=4, unsigned, a=15, b=15 -> 225 (carry retained). Signed mode a=-8 (4'b1000), b=-8 -> 64. Signed a=-8, b=7 -> -56 (8'hC8).
- WIDTH=8, signed, a=0, b=-1 -> product=0. SIGNED_EN=0 instance with signed_mode=1, a=8'hFF, b=8'h02 -> 510.
- start re-pulsed with a=1, b=1 during RUN of 3*5 -> ignored; product=15, a single done pulse; the next start in IDLE gives 1.
- start held high continuously with fixed operands -> done pulses every WIDTH+2 cycles, product constant.
- rst_n dropped for one cycle during RUN -> product=0, busy=0, no done pulse; a subsequent start completes normally.
